conv_kernel_fetcher: RTL

- Downstream consumer of the convolution kernel BRAM.
- For each accepted input spike event it walks all KERNEL_SIZE*KERNEL_SIZE kernel positions of the event's input channel, one position at a time.
- Each position yields one read word carrying the weights for every output channel.
- Emits a valid/ready weight stream (position + weights + last flag) to the convolution accumulate stage, with full throughput when that stage keeps ready asserted.

---
 rtl/conv_kernel_fetcher_if.sv | 49 ++++
 rtl/conv_kernel_fetcher.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_fetcher_if.sv
// Handshake/bus bundle for the kernel fetcher: event in, BRAM read port,
// and the weight stream towards the accumulate stage.
interface conv_kernel_fetcher_if #(
  parameter int KERNEL_WEIGHT_BITS = 6,
  parameter int KERNEL_SIZE        = 3,
  parameter int IN_CHANNELS        = 2,
  parameter int OUT_CHANNELS       = 2,
  parameter int ADDR_BITS          =
    $clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE),
  parameter int POS_BITS           = $clog2(KERNEL_SIZE)
);
  localparam int CH_BITS =
    (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int DW = OUT_CHANNELS*KERNEL_WEIGHT_BITS;

  logic                 evt_valid;
  logic                 evt_ready;
  logic [CH_BITS-1:0]   evt_channel;

  logic                 bram_en;
  logic                 bram_we;
  logic [ADDR_BITS-1:0] bram_addr;
  logic [DW-1:0]        bram_data_out;

  logic                 w_valid;
  logic                 w_ready;
  logic [POS_BITS-1:0]  w_kx;
  logic [POS_BITS-1:0]  w_ky;
  logic [DW-1:0]        w_weights;
  logic                 w_last;

  modport master (
    input  evt_valid, evt_channel,
    output evt_ready,
    output bram_en, bram_we, bram_addr,
    input  bram_data_out,
    output w_valid, w_kx, w_ky, w_weights, w_last,
    input  w_ready
  );

  modport slave (
    output evt_valid, evt_channel,
    input  evt_ready,
    input  bram_en, bram_we, bram_addr,
    output bram_data_out,
    input  w_valid, w_kx, w_ky, w_weights, w_last,
    output w_ready
  );
endinterface

// File: rtl/conv_kernel_fetcher.sv
// Walks the KxK kernel of an event's input channel, reading one BRAM word
// per position and streaming it out through a 2-entry credit-managed FIFO.
module conv_kernel_fetcher #(
  parameter int KERNEL_WEIGHT_BITS = 6,
  parameter int KERNEL_SIZE        = 3,
  parameter int IN_CHANNELS        = 2,
  parameter int OUT_CHANNELS       = 2,
  parameter int ADDR_BITS          =
    $clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE),
  parameter int POS_BITS           = $clog2(KERNEL_SIZE)
) (
  input  logic clk,
  input  logic rst_n,
  conv_kernel_fetcher_if.master bus,
  output logic busy,
  output logic err_chan
);
  localparam int KK      = KERNEL_SIZE*KERNEL_SIZE;
  localparam int CH_BITS =
    (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KP_BITS = (KK > 1) ? $clog2(KK) : 1;
  localparam int DW      = OUT_CHANNELS*KERNEL_WEIGHT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [CH_BITS-1:0]   chan_q;
  logic [KP_BITS-1:0]   kpos_q;
  logic [POS_BITS-1:0]  kx_q, ky_q;
  logic                 evt_ready_q;
  logic                 err_q;

  logic                 inf_q;
  logic [POS_BITS-1:0]  inf_kx_q, inf_ky_q;
  logic                 inf_last_q;

  logic [DW-1:0]        f_w_q    [2];
  logic [POS_BITS-1:0]  f_kx_q   [2];
  logic [POS_BITS-1:0]  f_ky_q   [2];
  logic                 f_last_q [2];
  logic                 wp_q, rp_q;
  logic [1:0]           cnt_q;

  logic                 chan_ok;
  logic                 evt_fire;
  logic                 wv;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic                 kpos_last;
  logic [2:0]           occ;

  generate
    if ((1 << CH_BITS) <= IN_CHANNELS) begin : g_full
      assign chan_ok = 1'b1;
    end else begin : g_chk
      assign chan_ok = int'(bus.evt_channel) < IN_CHANNELS;
    end
  endgenerate

  assign evt_fire  = bus.evt_valid & evt_ready_q;
  assign wv        = (cnt_q != 2'd0);
  assign pop       = wv & bus.w_ready;
  assign push      = inf_q;
  assign kpos_last = (kpos_q == KP_BITS'(KK-1));

  // Credit: buffered + in-flight words, minus the one leaving now.
  assign occ   = 3'(cnt_q) + 3'(inf_q) - 3'(pop);
  assign issue = (state_q == FETCH) && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (evt_fire && chan_ok) state_d = FETCH;
      FETCH:   if (issue && kpos_last) state_d = DRAIN;
      DRAIN:   if (pop && f_last_q[rp_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      kpos_q      <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      evt_ready_q <= 1'b0;
      err_q       <= 1'b0;
      inf_q       <= 1'b0;
      inf_kx_q    <= '0;
      inf_ky_q    <= '0;
      inf_last_q  <= 1'b0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        f_w_q[i]    <= '0;
        f_kx_q[i]   <= '0;
        f_ky_q[i]   <= '0;
        f_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      evt_ready_q <= (state_d == IDLE);
      err_q       <= evt_fire && !chan_ok;

      if (evt_fire && chan_ok) begin
        chan_q <= bus.evt_channel;
        kpos_q <= '0;
        kx_q   <= '0;
        ky_q   <= '0;
      end else if (issue) begin
        kpos_q <= kpos_q + 1'b1;
        if (kx_q == POS_BITS'(KERNEL_SIZE-1)) begin
          kx_q <= '0;
          ky_q <= ky_q + 1'b1;
        end else begin
          kx_q <= kx_q + 1'b1;
        end
      end

      // Position tags travel with the read until its data lands.
      inf_q <= issue;
      if (issue) begin
        inf_kx_q   <= kx_q;
        inf_ky_q   <= ky_q;
        inf_last_q <= kpos_last;
      end

      if (push) begin
        f_w_q[wp_q]    <= bus.bram_data_out;
        f_kx_q[wp_q]   <= inf_kx_q;
        f_ky_q[wp_q]   <= inf_ky_q;
        f_last_q[wp_q] <= inf_last_q;
        wp_q           <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign bus.evt_ready = evt_ready_q;
  assign bus.bram_en   = issue;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_addr =
    ADDR_BITS'(int'(chan_q)*KK + int'(kpos_q));

  assign bus.w_valid   = wv;
  assign bus.w_weights = f_w_q[rp_q];
  assign bus.w_kx      = f_kx_q[rp_q];
  assign bus.w_ky      = f_ky_q[rp_q];
  assign bus.w_last    = wv & f_last_q[rp_q];

  assign busy     = (state_q != IDLE);
  assign err_chan = err_q;
endmodule
